ppu_vram_arbiter: RTL and testbench
===================================

Name: ppu_vram_arbiter

Overview:
Owns the PPU's single video-memory bus and shares it between two requesters: the render fetch engine (tile, attribute and sprite pattern fetches) and the CPU-side $2007 data port. It sequences every access as an address phase followed by a data phase, generating the address-latch and active-low read/write strobes. Render traffic has priority, and a bounded-wait rule guarantees CPU progress.

Parameters:
CPU_MAX_WAIT, 4, number of consecutive decision cycles the CPU may lose to render before it is forced to win once; 0 = strict render priority.
ADDR_W, 14, video address width.

Ports:
clock  in  1  PPU master clock
reset  in  1  asynchronous, active-high reset
render_req  in  1  render request valid
render_addr  in  14  render fetch address
render_ack  out  1  combinational; request accepted this cycle
render_done  out  1  one-cycle pulse; render_rdata valid
render_rdata  out  8  registered read data
cpu_req  in  1  CPU request valid
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  14  CPU access address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  combinational; request accepted this cycle
cpu_done  out  1  one-cycle pulse; access complete, cpu_rdata valid for reads
cpu_rdata  out  8  registered read data
vram_addr  out  14  video bus address
vram_data_in  in  8  video bus read data
vram_data_out  out  8  video bus write data
vram_ale  out  1  address latch enable, high during ADDR
vram_rd_n  out  1  active-low read strobe
vram_wr_n  out  1  active-low write strobe
busy  out  1  high in ADDR or DATA

Behaviour:
- Reset: state IDLE; all *_ack/*_done 0; rdata 0; vram_addr 0; vram_data_out 0; vram_ale 0; vram_rd_n 1; vram_wr_n 1; wait counter 0. Reset mid-access aborts it at once; no done is issued.
- States: IDLE, ADDR, DATA. Decision cycles are IDLE and DATA.
- In a decision cycle, with at least one req high: assert exactly one ack. Latch addr, we (render always reads) and wdata, plus the owner. Next state is ADDR. With no req: IDLE->IDLE, DATA->IDLE.
- ADDR (1 cycle): vram_ale=1, vram_addr=latched addr, strobes high. Next state is DATA.
- DATA (1 cycle): vram_ale=0, vram_addr held. Read: vram_rd_n=0. Write: vram_wr_n=0 and vram_data_out=latched wdata (also driven in ADDR). At the closing edge, vram_data_in is registered into the owner's rdata and the owner's done goes high for the following cycle.
- Throughput: back-to-back accesses every 2 cycles. Latency from ack to done is 3 cycles.
- Handshake: req is valid, ack is ready. The requester may change addr or deassert req in the cycle after ack. done for an access can coincide with ack of that requester's next access.
- Priority, both req high: render wins unless wait counter == CPU_MAX_WAIT and CPU_MAX_WAIT != 0, in which case the CPU wins.
- Wait counter: +1 on each decision cycle where cpu_req=1 and render wins, saturating at CPU_MAX_WAIT; cleared on cpu_ack.
- Dropping req without an ack cancels the request with no side effects. Once acked, an access always completes.
- vram_addr wraps nothing; the caller masks addresses to 14 bits.

Optional Feature:
VRAM_ARB_STATS_EN. Defined: adds input stat_clear (1) and output stat_cpu_stall (16). The counter increments every cycle with cpu_req=1 and cpu_ack=0, saturates at 16'hFFFF, synchronously clears on stat_clear (clear wins over increment), and resets to 0. Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package ppu_vram_pkg holds:
  - the state enum (IDLE/ADDR/DATA)
  - the owner enum (OWN_RENDER/OWN_CPU)
  - VRAM_ADDR_W=14 and VRAM_DATA_W=8
- Sub-module ppu_vram_grant holds the priority decision and wait counter: req inputs plus decision-cycle flag in, one-hot ack out.

Test Plan:
- CPU read alone: cpu_req=1, cpu_addr=14'h2005, vram_data_in=8'hA7 during DATA -> ack at T0, ALE at T1, rd_n low at T2, cpu_done with cpu_rdata=8'hA7 at T3.
- CPU write: cpu_we=1, addr 14'h23C0, wdata 8'h5A -> wr_n low for one cycle with vram_data_out=8'h5A; rd_n stays 1; cpu_done pulses.
- Render stream: render_req held high with addresses 0x0000, 0x0010, 0x0020 -> ALE every 2 cycles and three render_done pulses 2 cycles apart.
- Contention, CPU_MAX_WAIT=4: both req held -> render acked 4 times, CPU acked on the 5th decision, wait counter back to 0. With CPU_MAX_WAIT=0 the CPU is never acked.
- Reset asserted during DATA of a read -> rd_n=1 and ale=0 immediately, no done, state IDLE after release.
- VRAM_ARB_STATS_EN: CPU stalled 6 cycles -> stat_cpu_stall=6; stat_clear with a stall in the same cycle -> 0.

Source files
------------

// File: rtl/ppu_vram_pkg.sv
// ppu_vram_pkg
//   Shared types and widths for the PPU video-memory arbiter.
//   - vram_state_e : bus sequencer state (IDLE / ADDR / DATA)
//   - vram_owner_e : which requester owns the access in flight
//   - VRAM_ADDR_W / VRAM_DATA_W : video bus widths
package ppu_vram_pkg;

   localparam int unsigned VRAM_ADDR_W = 14;
   localparam int unsigned VRAM_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } vram_state_e;

   typedef enum logic {
      OWN_RENDER = 1'b0,
      OWN_CPU    = 1'b1
   } vram_owner_e;

endpackage

// File: rtl/ppu_vram_grant.sv
// ppu_vram_grant
//   Priority decision between render and CPU requesters with a bounded-wait
//   counter so the CPU cannot be starved by a continuous render stream.
//   Ports:
//     clock_i, reset_i    : clock, asynchronous active-high reset
//     decide_i            : current cycle is a decision cycle
//     render_req_i        : render request valid
//     cpu_req_i           : CPU request valid
//     render_ack_o        : render granted this cycle (combinational)
//     cpu_ack_o           : CPU granted this cycle (combinational)
//   Parameter CPU_MAX_WAIT: decisions the CPU may lose before it is forced to
//   win once; 0 gives strict render priority.
module ppu_vram_grant #(
   parameter int unsigned CPU_MAX_WAIT = 4
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic decide_i,
   input  logic render_req_i,
   input  logic cpu_req_i,
   output logic render_ack_o,
   output logic cpu_ack_o
);

   localparam int unsigned WaitW = (CPU_MAX_WAIT > 1) ? $clog2(CPU_MAX_WAIT + 1) : 1;
   localparam logic [WaitW-1:0] WaitMax = WaitW'(CPU_MAX_WAIT);

   logic [WaitW-1:0] wait_q, wait_d;
   logic             force_cpu;

   always_comb begin
      force_cpu    = (CPU_MAX_WAIT != 0) && (wait_q == WaitMax);
      cpu_ack_o    = decide_i && cpu_req_i && (!render_req_i || force_cpu);
      render_ack_o = decide_i && render_req_i && !cpu_ack_o;

      wait_d = wait_q;
      if (cpu_ack_o) begin
         wait_d = '0;
      end else if (render_ack_o && cpu_req_i && (wait_q != WaitMax)) begin
         // Saturates at WaitMax; with CPU_MAX_WAIT = 0 it never moves.
         wait_d = wait_q + WaitW'(1);
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end

endmodule

// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter
//   Owns the PPU video-memory bus and shares it between the render fetch
//   engine and the CPU $2007 port. Each access is an ADDR cycle (ALE high)
//   followed by a DATA cycle (RD_N or WR_N low). IDLE and DATA are decision
//   cycles, giving back-to-back accesses every two cycles.
//   Ports:
//     clock, reset                       : clock, async active-high reset
//     render_req/addr, render_ack/done/rdata : render requester (reads only)
//     cpu_req/we/addr/wdata, cpu_ack/done/rdata : CPU requester
//     vram_addr, vram_data_in, vram_data_out, vram_ale, vram_rd_n, vram_wr_n
//                                        : video memory bus
//     busy                               : access in ADDR or DATA
//   Optional: define VRAM_ARB_STATS_EN to add stat_clear / stat_cpu_stall, a
//   saturating count of cycles the CPU requested without being acked.
module ppu_vram_arbiter
   import ppu_vram_pkg::*;
#(
   parameter int unsigned CPU_MAX_WAIT = 4,
   parameter int unsigned ADDR_W       = VRAM_ADDR_W
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   render_req,
   input  logic [ADDR_W-1:0]      render_addr,
   output logic                   render_ack,
   output logic                   render_done,
   output logic [VRAM_DATA_W-1:0] render_rdata,
   input  logic                   cpu_req,
   input  logic                   cpu_we,
   input  logic [ADDR_W-1:0]      cpu_addr,
   input  logic [VRAM_DATA_W-1:0] cpu_wdata,
   output logic                   cpu_ack,
   output logic                   cpu_done,
   output logic [VRAM_DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0]      vram_addr,
   input  logic [VRAM_DATA_W-1:0] vram_data_in,
   output logic [VRAM_DATA_W-1:0] vram_data_out,
   output logic                   vram_ale,
   output logic                   vram_rd_n,
   output logic                   vram_wr_n,
   output logic                   busy
`ifdef VRAM_ARB_STATS_EN
   ,
   input  logic                   stat_clear,
   output logic [15:0]            stat_cpu_stall
`endif
);

   vram_state_e            state_q, state_d;
   vram_owner_e            owner_q, owner_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic                   we_q, we_d;
   logic [VRAM_DATA_W-1:0] wdata_q, wdata_d;
   logic [VRAM_DATA_W-1:0] render_rdata_q, render_rdata_d;
   logic [VRAM_DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic                   render_done_q, render_done_d;
   logic                   cpu_done_q, cpu_done_d;
   logic                   decide;

   // Gated by reset so no ack can escape while reset is held.
   assign decide = !reset && ((state_q == IDLE) || (state_q == DATA));

   ppu_vram_grant #(
      .CPU_MAX_WAIT (CPU_MAX_WAIT)
   ) u_grant (
      .clock_i      (clock),
      .reset_i      (reset),
      .decide_i     (decide),
      .render_req_i (render_req),
      .cpu_req_i    (cpu_req),
      .render_ack_o (render_ack),
      .cpu_ack_o    (cpu_ack)
   );

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      addr_d         = addr_q;
      we_d           = we_q;
      wdata_d        = wdata_q;
      render_rdata_d = render_rdata_q;
      cpu_rdata_d    = cpu_rdata_q;
      render_done_d  = 1'b0;
      cpu_done_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (render_ack || cpu_ack) state_d = ADDR;
         end
         ADDR: begin
            state_d = DATA;
         end
         DATA: begin
            if (owner_q == OWN_RENDER) begin
               render_rdata_d = vram_data_in;
               render_done_d  = 1'b1;
            end else begin
               if (!we_q) cpu_rdata_d = vram_data_in;
               cpu_done_d = 1'b1;
            end
            state_d = (render_ack || cpu_ack) ? ADDR : IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Capture the granted request; the requester may move on next cycle.
      if (render_ack) begin
         owner_d = OWN_RENDER;
         addr_d  = render_addr;
         we_d    = 1'b0;
         wdata_d = '0;
      end else if (cpu_ack) begin
         owner_d = OWN_CPU;
         addr_d  = cpu_addr;
         we_d    = cpu_we;
         wdata_d = cpu_wdata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         owner_q        <= OWN_RENDER;
         addr_q         <= '0;
         we_q           <= 1'b0;
         wdata_q        <= '0;
         render_rdata_q <= '0;
         cpu_rdata_q    <= '0;
         render_done_q  <= 1'b0;
         cpu_done_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         addr_q         <= addr_d;
         we_q           <= we_d;
         wdata_q        <= wdata_d;
         render_rdata_q <= render_rdata_d;
         cpu_rdata_q    <= cpu_rdata_d;
         render_done_q  <= render_done_d;
         cpu_done_q     <= cpu_done_d;
      end
   end

   always_comb begin
      render_done   = render_done_q;
      cpu_done      = cpu_done_q;
      render_rdata  = render_rdata_q;
      cpu_rdata     = cpu_rdata_q;
      vram_addr     = addr_q;
      vram_ale      = (state_q == ADDR);
      vram_rd_n     = !((state_q == DATA) && !we_q);
      vram_wr_n     = !((state_q == DATA) && we_q);
      // Write data is presented from ADDR onward so it is settled before WR_N.
      vram_data_out = (we_q && (state_q != IDLE)) ? wdata_q : '0;
      busy          = (state_q != IDLE);
   end

`ifdef VRAM_ARB_STATS_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (stat_clear) begin
         stall_d = '0;
      end else if (cpu_req && !cpu_ack && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stat_cpu_stall = stall_q;
`endif

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// tb_ppu_vram_arbiter
//   Scoreboard bench for ppu_vram_arbiter. Accepted requests are pushed to
//   queues on ack; bus phases and done pulses pop and compare against them.
//   A second instance with CPU_MAX_WAIT = 0 shares the stimulus.
//   Stats checks are compiled in only with VRAM_ARB_STATS_EN.
module tb_ppu_vram_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        render_req;
   logic [13:0] render_addr;
   logic        cpu_req, cpu_we;
   logic [13:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        stat_clear;

   logic        render_ack, render_done, cpu_ack, cpu_done;
   logic [7:0]  render_rdata, cpu_rdata, vram_data_in, vram_data_out;
   logic [13:0] vram_addr;
   logic        vram_ale, vram_rd_n, vram_wr_n, busy;

   logic        render_ack0, render_done0, cpu_ack0, cpu_done0;
   logic [7:0]  render_rdata0, cpu_rdata0, vram_data_in0, vram_data_out0;
   logic [13:0] vram_addr0;
   logic        vram_ale0, vram_rd_n0, vram_wr_n0, busy0;
`ifdef VRAM_ARB_STATS_EN
   logic [15:0] stat_cpu_stall, stat_cpu_stall0;
`endif

   always #5 clock = ~clock;

   // Video memory contents as a fixed function of address.
   function automatic logic [7:0] pat(input logic [13:0] a);
      if (a == 14'h2005) return 8'hA7;
      return a[7:0] ^ {a[13:8], 2'b00} ^ 8'h3C;
   endfunction

   assign vram_data_in  = pat(vram_addr);
   assign vram_data_in0 = pat(vram_addr0);

   ppu_vram_arbiter #(.CPU_MAX_WAIT(4), .ADDR_W(14)) u_dut (
      .clock(clock), .reset(reset),
      .render_req(render_req), .render_addr(render_addr), .render_ack(render_ack),
      .render_done(render_done), .render_rdata(render_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
      .vram_addr(vram_addr), .vram_data_in(vram_data_in), .vram_data_out(vram_data_out),
      .vram_ale(vram_ale), .vram_rd_n(vram_rd_n), .vram_wr_n(vram_wr_n), .busy(busy)
`ifdef VRAM_ARB_STATS_EN
      , .stat_clear(stat_clear), .stat_cpu_stall(stat_cpu_stall)
`endif
   );

   ppu_vram_arbiter #(.CPU_MAX_WAIT(0), .ADDR_W(14)) u_dut_strict (
      .clock(clock), .reset(reset),
      .render_req(render_req), .render_addr(render_addr), .render_ack(render_ack0),
      .render_done(render_done0), .render_rdata(render_rdata0),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack0), .cpu_done(cpu_done0), .cpu_rdata(cpu_rdata0),
      .vram_addr(vram_addr0), .vram_data_in(vram_data_in0), .vram_data_out(vram_data_out0),
      .vram_ale(vram_ale0), .vram_rd_n(vram_rd_n0), .vram_wr_n(vram_wr_n0), .busy(busy0)
`ifdef VRAM_ARB_STATS_EN
      , .stat_clear(stat_clear), .stat_cpu_stall(stat_cpu_stall0)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      logic        we;
      logic [13:0] addr;
      logic [7:0]  wdata;
      int          ack_cyc;
   } txn_t;

   txn_t bus_q[$];
   txn_t rq[$];
   txn_t cq[$];
   logic order_q[$];
   logic rec_order = 1'b0;
   logic rec_strict = 1'b0;
   int   strict_cpu_acks = 0;
   int   strict_render_acks = 0;

   always @(posedge clock) cyc++;

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clock) begin
      txn_t h, t;
      if (reset) begin
         bus_q.delete();
         rq.delete();
         cq.delete();
      end else begin
         if (vram_ale) begin
            if (bus_q.size() == 0) check_eq("ale_unexpected", 1, 0);
            else begin
               h = bus_q[0];
               check_eq("ale_cycle", cyc, h.ack_cyc + 1);
               check_eq("ale_addr", vram_addr, h.addr);
               check_eq("ale_strobes", {vram_rd_n, vram_wr_n}, 2'b11);
            end
         end else if (!vram_rd_n || !vram_wr_n) begin
            if (bus_q.size() == 0) check_eq("data_unexpected", 1, 0);
            else begin
               h = bus_q.pop_front();
               check_eq("data_cycle", cyc, h.ack_cyc + 2);
               check_eq("data_addr", vram_addr, h.addr);
               check_eq("data_strobes", {vram_rd_n, vram_wr_n}, h.we ? 2'b10 : 2'b01);
               if (h.we) check_eq("data_wdata", vram_data_out, h.wdata);
            end
         end
         if (render_ack || cpu_ack) check_eq("ack_onehot", render_ack & cpu_ack, 0);
         if (render_ack) begin
            t.we = 1'b0; t.addr = render_addr; t.wdata = 8'h00; t.ack_cyc = cyc;
            bus_q.push_back(t);
            rq.push_back(t);
            if (rec_order) order_q.push_back(1'b0);
         end
         if (cpu_ack) begin
            t.we = cpu_we; t.addr = cpu_addr; t.wdata = cpu_wdata; t.ack_cyc = cyc;
            bus_q.push_back(t);
            cq.push_back(t);
            if (rec_order) order_q.push_back(1'b1);
         end
         if (render_done) begin
            if (rq.size() == 0) check_eq("render_done_unexpected", 1, 0);
            else begin
               h = rq.pop_front();
               check_eq("render_done_cycle", cyc, h.ack_cyc + 3);
               check_eq("render_rdata", render_rdata, pat(h.addr));
            end
         end
         if (cpu_done) begin
            if (cq.size() == 0) check_eq("cpu_done_unexpected", 1, 0);
            else begin
               h = cq.pop_front();
               check_eq("cpu_done_cycle", cyc, h.ack_cyc + 3);
               if (!h.we) check_eq("cpu_rdata", cpu_rdata, pat(h.addr));
            end
         end
         if (rec_strict && cpu_ack0) strict_cpu_acks++;
         if (rec_strict && render_ack0) strict_render_acks++;
      end
   end

   task automatic render_stream(input int n, input logic [13:0] base, input logic [13:0] stride,
                                input bit chk_gap);
      int prev = 0;
      int k;
      for (int i = 0; i < n; i++) begin
         render_req  = 1'b1;
         render_addr = base + 14'(i) * stride;
         for (k = 0; k < 64; k++) begin
            @(negedge clock);
            if (render_ack) break;
         end
         if (k == 64) begin
            check_eq("render_ack_timeout", 0, 1);
            break;
         end
         if (chk_gap && i > 0) check_eq("render_ack_gap", cyc - prev, 2);
         prev = cyc;
         @(posedge clock); #1;
      end
      render_req = 1'b0;
   endtask

   task automatic cpu_stream(input int n, input logic we, input logic [13:0] base,
                             input logic [7:0] wbase);
      int k;
      for (int i = 0; i < n; i++) begin
         cpu_req   = 1'b1;
         cpu_we    = we;
         cpu_addr  = base + 14'(i);
         cpu_wdata = wbase + 8'(i);
         for (k = 0; k < 64; k++) begin
            @(negedge clock);
            if (cpu_ack) break;
         end
         if (k == 64) begin
            check_eq("cpu_ack_timeout", 0, 1);
            break;
         end
         @(posedge clock); #1;
      end
      cpu_req = 1'b0;
   endtask

   task automatic wait_cpu_done(input string tag);
      int k;
      for (k = 0; k < 8; k++) begin
         @(negedge clock);
         if (cpu_done) break;
      end
      if (k == 8) check_eq(tag, 0, 1);
   endtask

   logic exp_order [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                            1'b0, 1'b0};

   initial begin
      reset = 1'b1; stat_clear = 1'b0;
      render_req = 1'b1; render_addr = 14'h0155;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0AAA; cpu_wdata = 8'h00;
      repeat (2) @(posedge clock);
      @(negedge clock);
      // Reset state, with both requests raised to show no ack leaks out.
      check_eq("rst_render_ack", render_ack, 0);
      check_eq("rst_cpu_ack", cpu_ack, 0);
      check_eq("rst_dones", {render_done, cpu_done}, 2'b00);
      check_eq("rst_rdata", {render_rdata, cpu_rdata}, 16'h0000);
      check_eq("rst_vram_addr", vram_addr, 14'h0000);
      check_eq("rst_data_out", vram_data_out, 8'h00);
      check_eq("rst_strobes", {vram_ale, vram_rd_n, vram_wr_n}, 3'b011);
      check_eq("rst_busy", busy, 0);
      render_req = 1'b0; cpu_req = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (2) @(posedge clock); #1;

      // CPU read alone.
      cpu_stream(1, 1'b0, 14'h2005, 8'h00);
      wait_cpu_done("cpu_read_done_timeout");
      check_eq("cpu_read_A7", cpu_rdata, 8'hA7);
      repeat (3) @(posedge clock); #1;

      // CPU write.
      cpu_stream(1, 1'b1, 14'h23C0, 8'h5A);
      wait_cpu_done("cpu_write_done_timeout");
      check_eq("cpu_rdata_kept_after_write", cpu_rdata, 8'hA7);
      repeat (3) @(posedge clock); #1;

      // Render stream, back-to-back.
      render_stream(3, 14'h0000, 14'h0010, 1'b1);
      repeat (6) @(posedge clock); #1;

      // Contention with both requests held.
      rec_order = 1'b1; rec_strict = 1'b1;
      fork
         render_stream(10, 14'h0100, 14'h0001, 1'b0);
         cpu_stream(2, 1'b0, 14'h3F00, 8'h00);
      join
      rec_order = 1'b0; rec_strict = 1'b0;
      check_eq("order_len", order_q.size(), 12);
      for (int i = 0; i < 12 && i < order_q.size(); i++)
         check_eq($sformatf("order_%0d", i), order_q[i], exp_order[i]);
      check_eq("strict_cpu_acks", strict_cpu_acks, 0);
      check_eq("strict_render_seen", strict_render_acks > 0, 1);
      repeat (6) @(posedge clock); #1;

      // Reset during the DATA cycle of a CPU read.
      cpu_stream(1, 1'b0, 14'h1234, 8'h00);
      @(posedge clock); #1;
      check_eq("abort_pre_rd_n", vram_rd_n, 0);
      reset = 1'b1;
      #1;
      check_eq("abort_rd_n", vram_rd_n, 1);
      check_eq("abort_ale", vram_ale, 0);
      check_eq("abort_busy", busy, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check_eq("abort_no_done", cpu_done, 0);
         check_eq("abort_idle", busy, 0);
      end
      @(posedge clock); #1;

`ifdef VRAM_ARB_STATS_EN
      // CPU stalls through 4 render grants: 8 cycles of req without ack.
      fork
         render_stream(6, 14'h0200, 14'h0001, 1'b0);
         cpu_stream(1, 1'b0, 14'h0300, 8'h00);
      join
      @(negedge clock);
      check_eq("stat_stall_count", stat_cpu_stall, 8);
      repeat (4) @(posedge clock); #1;
      fork
         render_stream(4, 14'h0210, 14'h0001, 1'b0);
         cpu_stream(1, 1'b0, 14'h0310, 8'h00);
         begin
            repeat (2) @(posedge clock); #1;
            stat_clear = 1'b1;
            @(posedge clock); #1;
            stat_clear = 1'b0;
            check_eq("stat_clear_wins", stat_cpu_stall, 0);
         end
      join
      repeat (4) @(posedge clock); #1;
`endif

      repeat (8) @(posedge clock);
      @(negedge clock);
      check_eq("bus_q_drained", bus_q.size(), 0);
      check_eq("rq_drained", rq.size(), 0);
      check_eq("cq_drained", cq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1, "watchdog");
   end

endmodule
